// File: rtl/canny_frame_sequencer.sv
// Frame sequencer for the Canny edge datapath: streams a source frame out of
// memory with video timing, appends zero pad lines to flush the pipeline, and
// writes the edge results (minus the leading latency beats) to a result memory.
module canny_frame_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned H_RES     = 170,
  parameter int unsigned V_RES     = 120,
  parameter int unsigned HB_LEN    = 16,
  parameter int unsigned VS_LEN    = 4,
  parameter int unsigned PAD_LINES = 2,
  parameter int unsigned SKIP      = 2*H_RES,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DRAIN_MAX = 3*(H_RES+HB_LEN)+64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              px_vsync,
  output logic              px_hsync,
  output logic              px_de,
  output logic [WIDTH-1:0]  px_data,
  input  logic              ed_de,
  input  logic [WIDTH-1:0]  ed_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned N_PIX     = H_RES*V_RES;
  localparam int unsigned LAST_LINE = V_RES+PAD_LINES-1;

  typedef enum logic [2:0] {IDLE, VSYNC, ACTIVE, HBLANK, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       line_q, line_d;
  logic [31:0]       beat_q, beat_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              px_vsync_q, px_vsync_d;
  logic              px_hsync_q, px_hsync_d;
  logic              px_de_q, px_de_d;
  logic              pad_q, pad_d;
  logic              err_q, err_d;
  logic              vs_term, hs_term, de_term, accept;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic with the state-local cycle/line counters and error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        line_d = '0;
        if (start && !abort) begin
          state_d = VSYNC;
          err_d   = 1'b0;
        end
      end
      VSYNC: if (cnt_q == VS_LEN-1) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        line_d  = '0;
      end
      ACTIVE: if (cnt_q == H_RES-1) begin
        state_d = HBLANK;
        cnt_d   = '0;
      end
      HBLANK: if (cnt_q == HB_LEN-1) begin
        cnt_d = '0;
        if (line_q == LAST_LINE) state_d = DRAIN;
        else begin
          state_d = ACTIVE;
          line_d  = line_q + 32'd1;
        end
      end
      DRAIN: begin
        if (wr_cnt_q == N_PIX) state_d = DONE;
        else if (cnt_q == DRAIN_MAX-1) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = err_q;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    vs_term = (state_q == VSYNC);
    hs_term = (state_q == HBLANK);
    de_term = (state_q == ACTIVE);
    rd_en   = de_term && (line_q < V_RES);
  end

  // Datapath: read address, registered pixel timing, beat counting and writes
  always_comb begin
    rd_addr_d  = rd_addr_q;
    beat_d     = beat_q;
    wr_cnt_d   = wr_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    px_vsync_d = vs_term && !abort;
    px_hsync_d = hs_term && !abort;
    px_de_d    = de_term && !abort;
    pad_d      = (line_q >= V_RES);
    accept     = ed_de && busy && !abort && (beat_q >= SKIP) && (wr_cnt_q < N_PIX);
    if (!busy) begin
      rd_addr_d = '0;
      beat_d    = '0;
      wr_cnt_d  = '0;
      wr_addr_d = '0;
    end else begin
      if (rd_en) rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (ed_de) beat_d = beat_q + 32'd1;
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_cnt_q[ADDR_W-1:0];
        wr_data_d = ed_data;
        wr_cnt_d  = wr_cnt_q + 32'd1;
      end
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      px_vsync_q <= 1'b0;
      px_hsync_q <= 1'b0;
      px_de_q    <= 1'b0;
      pad_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      px_vsync_q <= px_vsync_d;
      px_hsync_q <= px_hsync_d;
      px_de_q    <= px_de_d;
      pad_q      <= pad_d;
      err_q      <= err_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign px_vsync = px_vsync_q;
  assign px_hsync = px_hsync_q;
  assign px_de    = px_de_q;
  // rd_data arrives with the registered timing, so it is gated combinationally
  assign px_data  = (px_de_q && !pad_q) ? rd_data : '0;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;

endmodule
